// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its issuer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mult_div_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Operation select carried on the op input
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/cond_negate.sv
// Two's-complement negate-if: o_y = i_neg ? -i_x : i_x.
// Latency: combinational.
// Backpressure: none.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_neg ? (~i_x + WIDTH'(1)) : i_x;

endmodule

// File: rtl/mult_div_seq.sv
// Iterative shift-add multiplier / restoring divider, signed or unsigned, HI/LO results.
// Latency: WIDTH+1 edges from accepted start to done; divide-by-zero answers after 1 edge.
// Backpressure: start is ignored while busy; no queuing, caller waits for done.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             RESET_in,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             Div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Sequencer state
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_neg_q;    // negate product / quotient at FIX
    logic               r_neg_r;    // negate remainder at FIX
    // Accumulator: multiply = {partial product, multiplier}; divide = {remainder, quotient}
    logic [2*WIDTH-1:0] r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0]   r_opd;

    // Registered outputs
    logic               r_busy;
    logic               r_done;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes and sign-fixed results
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // One-iteration datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_x   (a),
        .i_neg (sgn & a[WIDTH-1]),
        .o_y   (w_abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_x   (b),
        .i_neg (sgn & b[WIDTH-1]),
        .o_y   (w_abs_b)
    );

    // Product is negated as a full 2*WIDTH value so the borrow crosses into HI
    cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_x   (r_acc),
        .i_neg (r_neg_q),
        .o_y   (w_prod_fix)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .i_x   (r_acc[WIDTH-1:0]),
        .i_neg (r_neg_q),
        .o_y   (w_quo_fix)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .i_x   (r_acc[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_r),
        .o_y   (w_rem_fix)
    );

    // Next accumulator value for one multiply step and one divide step
    always_comb begin
        // Multiply: add multiplicand to the upper half when the current multiplier LSB is set, then shift right
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder, keep the difference if it did not go negative.
        // The remainder is always below the divisor, so the shifted value stays below 2*divisor and
        // bit WIDTH of the difference is a reliable borrow.
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opd};
        w_div_ge    = ~w_div_diff[WIDTH];
        w_div_next  = w_div_ge ? {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1}
                               : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end

    // Sequencer FSM, iteration datapath and registered outputs
    always_ff @(posedge clock) begin
        if (RESET_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_DIV && b == '0) begin
                            // Answer immediately; HI/LO keep the previous result
                            r_done <= 1'b1;
                            r_div0 <= 1'b1;
                        end else begin
                            r_op    <= op;
                            r_neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= sgn & a[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                            if (op == OP_MULT) begin
                                r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opd <= w_abs_a;
                            end else begin
                                r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opd <= w_abs_b;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= (r_op == OP_MULT) ? w_mul_next : w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_op == OP_MULT) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: 32-bit and 8-bit builds, directed and random operations.
// Expected results come from plain integer arithmetic on sign-extended operands.
// Every wait for done is bounded; a missing done counts as a failed check.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32;
    logic        start8;
    logic        op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;

    logic        busy32, done32, div032;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    int          sel;
    int          n_checks = 0;
    int          n_err    = 0;

    // Last committed HI/LO per build (index 0 = 32-bit, 1 = 8-bit)
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    logic        o_busy, o_done, o_div0;
    logic [31:0] o_hi, o_lo;

    mult_div_seq #(.WIDTH(32)) u_dut32 (
        .clock    (clk),
        .RESET_in (rst),
        .start    (start32),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .busy     (busy32),
        .done     (done32),
        .Div0     (div032),
        .hi       (hi32),
        .lo       (lo32)
    );

    mult_div_seq #(.WIDTH(8)) u_dut8 (
        .clock    (clk),
        .RESET_in (rst),
        .start    (start8),
        .op       (op),
        .sgn      (sgn),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .busy     (busy8),
        .done     (done8),
        .Div0     (div08),
        .hi       (hi8),
        .lo       (lo8)
    );

    always_comb begin
        if (sel == 1) begin
            o_busy = busy8;
            o_done = done8;
            o_div0 = div08;
            o_hi   = {24'h0, hi8};
            o_lo   = {24'h0, lo8};
        end else begin
            o_busy = busy32;
            o_done = done32;
            o_div0 = div032;
            o_hi   = hi32;
            o_lo   = lo32;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sign-extend to 64 bits, use native multiply / truncating divide, keep w bits per half
    function automatic void model(input int w, input logic o, input logic s,
                                  input logic [31:0] ai, input logic [31:0] bi,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint mask;
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(ai) & mask;
        sb   = longint'(bi) & mask;
        if (s && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
        if (s && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
        if (!o) begin
            p  = sa * sb;
            el = 32'(p & mask);
            eh = 32'((p >> w) & mask);
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = 32'(q & mask);
            eh = 32'(r & mask);
        end
    endfunction

    // Issue one operation on build d and check timing, flags and results at done.
    // b2b=1 means the caller is already sitting in the previous done cycle and issues there.
    task automatic run_op(input int d, input bit b2b, input logic o, input logic s,
                          input logic [31:0] ai, input logic [31:0] bi, input string tag,
                          output logic [31:0] got_hi, output logic [31:0] got_lo);
        int          w;
        int          n;
        int          bc;
        logic [31:0] mask;
        logic [31:0] eh;
        logic [31:0] el;
        bit          ediv0;
        w     = (d == 1) ? 8 : 32;
        mask  = (d == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        ediv0 = o && ((bi & mask) == 32'h0);
        if (ediv0) begin
            eh = m_hi[d];
            el = m_lo[d];
        end else begin
            model(w, o, s, ai, bi, eh, el);
            m_hi[d] = eh;
            m_lo[d] = el;
        end
        if (!b2b) @(negedge clk);
        sel = d;
        op  = o;
        sgn = s;
        a   = ai;
        b   = bi;
        if (d == 1) start8 = 1'b1;
        else        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        start8  = 1'b0;
        // Operands only matter in the start cycle
        op  = 1'($urandom_range(0, 1));
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom;
        n   = 1;
        bc  = 0;
        while (!o_done && n < 100) begin
            if (o_busy) bc++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(o_done), 64'(1));
        chk({tag, "_done_cycle"}, 64'(n), ediv0 ? 64'(1) : 64'(w + 2));
        chk({tag, "_busy_cycles"}, 64'(bc), ediv0 ? 64'(0) : 64'(w + 1));
        chk({tag, "_busy_at_done"}, 64'(o_busy), 64'(0));
        chk({tag, "_div0"}, 64'(o_div0), 64'(ediv0));
        chk({tag, "_hi"}, 64'(o_hi), 64'(eh));
        chk({tag, "_lo"}, 64'(o_lo), 64'(el));
        got_hi = o_hi;
        got_lo = o_lo;
    endtask

    initial begin
        logic [31:0] gh;
        logic [31:0] gl;
        logic [31:0] eh;
        logic [31:0] el;
        int          dones;
        int          div0s;

        rst     = 1'b1;
        start32 = 1'b0;
        start8  = 1'b0;
        op      = 1'b0;
        sgn     = 1'b0;
        a       = '0;
        b       = '0;
        sel     = 0;
        m_hi[0] = '0; m_lo[0] = '0;
        m_hi[1] = '0; m_lo[1] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy32", 64'(busy32), 64'(0));
        chk("rst_done32", 64'(done32), 64'(0));
        chk("rst_div032", 64'(div032), 64'(0));
        chk("rst_hi32",   64'(hi32),   64'(0));
        chk("rst_lo32",   64'(lo32),   64'(0));
        chk("rst_busy8",  64'(busy8),  64'(0));
        chk("rst_hilo8",  64'({hi8, lo8}), 64'(0));
        rst = 1'b0;

        // Directed 32-bit cases with hand-computed results
        run_op(0, 1'b0, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, "smul_7_m3", gh, gl);
        chk("smul_7_m3_hi_const", 64'(gh), 64'hFFFF_FFFF);
        chk("smul_7_m3_lo_const", 64'(gl), 64'hFFFF_FFEB);

        run_op(0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2", gh, gl);
        chk("sdiv_m7_2_lo_const", 64'(gl), 64'hFFFF_FFFD);
        chk("sdiv_m7_2_hi_const", 64'(gh), 64'hFFFF_FFFF);

        run_op(0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, "udiv_max_16", gh, gl);
        chk("udiv_max_16_lo_const", 64'(gl), 64'h0FFF_FFFF);
        chk("udiv_max_16_hi_const", 64'(gh), 64'hF);

        run_op(0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_minneg_m1", gh, gl);
        chk("sdiv_minneg_m1_lo_const", 64'(gl), 64'h8000_0000);
        chk("sdiv_minneg_m1_hi_const", 64'(gh), 64'h0);

        run_op(0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max_sq", gh, gl);
        chk("umul_max_sq_hi_const", 64'(gh), 64'hFFFF_FFFE);
        chk("umul_max_sq_lo_const", 64'(gl), 64'h1);

        // Prior result hi=5 lo=9, then divide by zero must keep it
        run_op(0, 1'b0, 1'b1, 1'b0, 32'd95, 32'd10, "udiv_95_10", gh, gl);
        chk("udiv_95_10_hi_const", 64'(gh), 64'd5);
        chk("udiv_95_10_lo_const", 64'(gl), 64'd9);
        run_op(0, 1'b0, 1'b1, 1'b1, 32'd123, 32'd0, "div_by_zero", gh, gl);
        chk("div_by_zero_hi_kept", 64'(gh), 64'd5);
        chk("div_by_zero_lo_kept", 64'(gl), 64'd9);
        @(negedge clk);
        chk("div_by_zero_done_pulse", 64'({done32, div032, busy32}), 64'(0));

        // Reset in the middle of RUN aborts with no done
        sel     = 0;
        op      = 1'b0;
        sgn     = 1'b1;
        a       = 32'h1234_5678;
        b       = 32'hFEDC_BA98;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_outputs", 64'({busy32, done32, div032, hi32, lo32}), 64'(0));
        m_hi[0] = '0; m_lo[0] = '0;
        m_hi[1] = '0; m_lo[1] = '0;
        dones = 0;
        repeat (45) begin
            @(negedge clk);
            if (done32) dones++;
        end
        chk("midrun_rst_no_done", 64'(dones), 64'(0));

        // start during RUN is ignored: exactly one done carrying the first operation's result
        model(32, 1'b0, 1'b1, 32'd1234, 32'hFFFF_FFB3, eh, el);
        sel     = 0;
        op      = 1'b0;
        sgn     = 1'b1;
        a       = 32'd1234;
        b       = 32'hFFFF_FFB3;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        op      = 1'b1;
        a       = 32'd77;
        b       = 32'd0;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        dones = 0;
        div0s = 0;
        gh    = '0;
        gl    = '0;
        repeat (45) begin
            @(negedge clk);
            if (div032) div0s++;
            if (done32) begin
                dones++;
                gh = hi32;
                gl = lo32;
            end
        end
        chk("busy_start_single_done", 64'(dones), 64'(1));
        chk("busy_start_no_div0",     64'(div0s), 64'(0));
        chk("busy_start_hi",          64'(gh),    64'(eh));
        chk("busy_start_lo",          64'(gl),    64'(el));
        m_hi[0] = eh;
        m_lo[0] = el;

        // 8-bit build: -128 x -128, then back-to-back start in the done cycle
        run_op(1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80, "w8_smul_m128sq", gh, gl);
        chk("w8_smul_m128sq_hi_const", 64'(gh), 64'h40);
        chk("w8_smul_m128sq_lo_const", 64'(gl), 64'h00);
        run_op(1, 1'b1, 1'b1, 1'b1, 32'h80, 32'hFF, "w8_b2b_sdiv", gh, gl);
        chk("w8_b2b_sdiv_lo_const", 64'(gl), 64'h80);
        chk("w8_b2b_sdiv_hi_const", 64'(gh), 64'h00);

        // Random operations on both builds, some small divisors, some zero divisors, some back-to-back
        for (int i = 0; i < 40; i++) begin
            int          d;
            bit          bb;
            logic        ro;
            logic        rs;
            logic [31:0] ra;
            logic [31:0] rb;
            d  = int'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_000F;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            bb = (i > 0) && ($urandom_range(0, 1) == 1);
            run_op(d, bb, ro, rs, ra, rb, "rand", gh, gl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
